// File: rtl/adc_spi_responder_if.sv
// SPI pin bundle for the ADCio link between the link master and the ADC responder.
interface adc_spi_responder_if;
    logic ADC_sclk;
    logic ADC_ss;
    logic ADC_Din;
    logic ADC_Dout;

    modport master (
        output ADC_sclk,
        output ADC_ss,
        output ADC_Din,
        input  ADC_Dout
    );

    modport slave (
        input  ADC_sclk,
        input  ADC_ss,
        input  ADC_Din,
        output ADC_Dout
    );
endinterface

// File: rtl/adc_spi_responder.sv
// Clock-oversampled SPI responder modelling an 8-channel ADC: decodes a 3-bit channel
// address per frame and returns the sample for the channel addressed in the previous frame.
module adc_spi_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = 16,
    parameter int DATA_W      = 12
) (
    input  logic                  clkADC,
    input  logic                  rst,
    adc_spi_responder_if.slave    spi,
    input  logic [8*DATA_W-1:0]   ch_data,
    output logic [2:0]            cur_ch,
    output logic                  frame_done,
    output logic                  frame_err
);

    localparam int CNT_W = $clog2(FRAME_BITS + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Zero-extended sample placed in the low bits of the outgoing frame word.
    function automatic logic [FRAME_BITS-1:0] frame_word(input logic [DATA_W-1:0] sample);
        logic [FRAME_BITS-1:0] w;
        w = {FRAME_BITS{1'b0}};
        w[DATA_W-1:0] = sample;
        return w;
    endfunction

    logic [SYNC_STAGES-1:0] sclk_sync_r;
    logic [SYNC_STAGES-1:0] ss_sync_r;
    logic [SYNC_STAGES-1:0] din_sync_r;
    logic                   sclk_prev_r;
    logic                   ss_prev_r;

    logic                   sclk_s;
    logic                   ss_s;
    logic                   din_s;
    logic                   sclk_rise_s;
    logic                   sclk_fall_s;
    logic                   ss_rise_s;
    logic                   ss_fall_s;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [CNT_W-1:0]       rise_cnt_r;
    logic [CNT_W-1:0]       cnt_nxt_s;
    logic [CNT_W-1:0]       cnt_inc_s;
    logic [2:0]             addr_r;
    logic [2:0]             addr_nxt_s;
    logic [FRAME_BITS-1:0]  shift_r;
    logic [FRAME_BITS-1:0]  shift_nxt_s;
    logic                   done_evt_s;
    logic                   err_evt_s;
    logic                   done_evt_r;
    logic                   err_evt_r;
    logic [DATA_W-1:0]      sel_sample_s;

    logic                   dout_r;
    logic [2:0]             cur_ch_r;
    logic                   frame_done_r;
    logic                   frame_err_r;

    // Pin synchronisers plus one-cycle history for edge detection.
    // SS resets low so a frame only starts after SS has been seen high.
    always_ff @(posedge clkADC or posedge rst) begin
        if (rst) begin
            sclk_sync_r <= {SYNC_STAGES{1'b1}};
            ss_sync_r   <= {SYNC_STAGES{1'b0}};
            din_sync_r  <= {SYNC_STAGES{1'b0}};
            sclk_prev_r <= 1'b1;
            ss_prev_r   <= 1'b0;
        end else begin
            sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], spi.ADC_sclk};
            ss_sync_r   <= {ss_sync_r[SYNC_STAGES-2:0], spi.ADC_ss};
            din_sync_r  <= {din_sync_r[SYNC_STAGES-2:0], spi.ADC_Din};
            sclk_prev_r <= sclk_sync_r[SYNC_STAGES-1];
            ss_prev_r   <= ss_sync_r[SYNC_STAGES-1];
        end
    end

    assign sclk_s       = sclk_sync_r[SYNC_STAGES-1];
    assign ss_s         = ss_sync_r[SYNC_STAGES-1];
    assign din_s        = din_sync_r[SYNC_STAGES-1];
    assign sclk_rise_s  = sclk_s & ~sclk_prev_r;
    assign sclk_fall_s  = ~sclk_s & sclk_prev_r;
    assign ss_rise_s    = ss_s & ~ss_prev_r;
    assign ss_fall_s    = ~ss_s & ss_prev_r;
    assign cnt_inc_s    = rise_cnt_r + CNT_W'(1);
    assign sel_sample_s = ch_data[32'(cur_ch_r) * DATA_W +: DATA_W];

    // Frame FSM next-state and datapath; SS edges take priority over SCLK edges.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = rise_cnt_r;
        addr_nxt_s  = addr_r;
        shift_nxt_s = shift_r;
        done_evt_s  = 1'b0;
        err_evt_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (ss_fall_s) begin
                    state_nxt_s = ST_ACTIVE;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                    addr_nxt_s  = 3'd0;
                    shift_nxt_s = frame_word(sel_sample_s);
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (ss_rise_s) begin
                    state_nxt_s = ST_IDLE;
                    err_evt_s   = 1'b1;
                end else if (sclk_rise_s) begin
                    cnt_nxt_s = cnt_inc_s;
                    case (cnt_inc_s)
                        CNT_W'(3): addr_nxt_s[2] = din_s;
                        CNT_W'(4): addr_nxt_s[1] = din_s;
                        CNT_W'(5): addr_nxt_s[0] = din_s;
                        default:   addr_nxt_s    = addr_r;
                    endcase
                    if (cnt_inc_s == CNT_W'(FRAME_BITS)) begin
                        state_nxt_s = ST_DONE;
                        done_evt_s  = 1'b1;
                    end else begin
                        state_nxt_s = ST_ACTIVE;
                    end
                end else if (sclk_fall_s && (rise_cnt_r != {CNT_W{1'b0}})) begin
                    shift_nxt_s = {shift_r[FRAME_BITS-2:0], 1'b0};
                end else begin
                    state_nxt_s = ST_ACTIVE;
                end
            end
            ST_DONE: begin
                if (ss_rise_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state and frame datapath registers.
    always_ff @(posedge clkADC or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            rise_cnt_r <= {CNT_W{1'b0}};
            addr_r     <= 3'd0;
            shift_r    <= {FRAME_BITS{1'b0}};
            done_evt_r <= 1'b0;
            err_evt_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            rise_cnt_r <= cnt_nxt_s;
            addr_r     <= addr_nxt_s;
            shift_r    <= shift_nxt_s;
            done_evt_r <= done_evt_s;
            err_evt_r  <= err_evt_s;
        end
    end

    // Output registers; DOUT is forced low outside an active frame.
    always_ff @(posedge clkADC or posedge rst) begin
        if (rst) begin
            dout_r       <= 1'b0;
            cur_ch_r     <= 3'd0;
            frame_done_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            dout_r       <= (state_r == ST_ACTIVE) ? shift_r[FRAME_BITS-1] : 1'b0;
            cur_ch_r     <= done_evt_r ? addr_r : cur_ch_r;
            frame_done_r <= done_evt_r;
            frame_err_r  <= err_evt_r;
        end
    end

    assign spi.ADC_Dout = dout_r;
    assign cur_ch       = cur_ch_r;
    assign frame_done   = frame_done_r;
    assign frame_err    = frame_err_r;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed bench for adc_spi_responder: drives SPI frames from the master side and
// compares returned words, pulses and channel pipelining against hand-computed values.
module tb_adc_spi_responder;
    localparam int SYNC_STAGES = 2;
    localparam int FRAME_BITS  = 16;
    localparam int DATA_W      = 12;
    localparam int HALF        = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic [8*DATA_W-1:0] ch_data;
    logic [2:0]          cur_ch;
    logic                frame_done;
    logic                frame_err;

    adc_spi_responder_if spi_if();

    adc_spi_responder #(
        .SYNC_STAGES(SYNC_STAGES),
        .FRAME_BITS (FRAME_BITS),
        .DATA_W     (DATA_W)
    ) dut (
        .clkADC    (clk),
        .rst       (rst),
        .spi       (spi_if),
        .ch_data   (ch_data),
        .cur_ch    (cur_ch),
        .frame_done(frame_done),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         done_cnt = 0;
    int         err_cnt = 0;
    int         last_done_cyc = 0;
    logic [2:0] last_done_ch = 3'd0;
    always @(negedge clk) begin
        if (frame_done) begin
            done_cnt      <= done_cnt + 1;
            last_done_cyc <= cyc;
            last_done_ch  <= cur_ch;
        end
        if (frame_err) err_cnt <= err_cnt + 1;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int rise16_cyc = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [DATA_W-1:0] v);
        ch_data[ch*DATA_W +: DATA_W] = v;
    endtask

    task automatic run_frame(input logic [15:0] din_word, input int n_rises,
                             input int late_ch, input logic [DATA_W-1:0] late_val,
                             input bit late_en,
                             output logic [15:0] dout_word, output bit extra_nz);
        dout_word = 16'h0000;
        extra_nz  = 1'b0;
        spi_if.ADC_ss = 1'b0;
        tick(HALF);
        if (late_en) set_ch(late_ch, late_val);
        for (int k = 1; k <= n_rises; k++) begin
            spi_if.ADC_sclk = 1'b0;
            if (k <= 16) spi_if.ADC_Din = din_word[16-k];
            else         spi_if.ADC_Din = 1'b0;
            tick(HALF);
            if (k <= 16) dout_word[16-k] = spi_if.ADC_Dout;
            else if (spi_if.ADC_Dout) extra_nz = 1'b1;
            spi_if.ADC_sclk = 1'b1;
            if (k == 16) rise16_cyc = cyc;
            tick(HALF);
        end
        spi_if.ADC_ss = 1'b1;
        tick(HALF);
    endtask

    logic [15:0] dw;
    bit          nz;
    int          d0;
    int          e0;

    initial begin
        rst = 1'b1;
        spi_if.ADC_sclk = 1'b1;
        spi_if.ADC_ss   = 1'b1;
        spi_if.ADC_Din  = 1'b0;
        ch_data = '0;
        set_ch(0, 12'hABC); set_ch(1, 12'h111); set_ch(2, 12'hFFF); set_ch(3, 12'h333);
        set_ch(4, 12'h444); set_ch(5, 12'h123); set_ch(6, 12'h666); set_ch(7, 12'h7A5);
        tick(3);
        check_eq("rst_dout", 32'(spi_if.ADC_Dout), 32'h0);
        check_eq("rst_cur_ch", 32'(cur_ch), 32'h0);
        check_eq("rst_done", 32'(frame_done), 32'h0);
        check_eq("rst_err", 32'(frame_err), 32'h0);
        rst = 1'b0;
        tick(4);

        // first frame after reset returns channel 0
        d0 = done_cnt; e0 = err_cnt;
        run_frame(16'h0000, 16, 0, 12'h000, 1'b0, dw, nz);
        check_eq("f1_dout", 32'(dw), 32'h0ABC);
        check_eq("f1_done_cnt", 32'(done_cnt - d0), 32'd1);
        check_eq("f1_err_cnt", 32'(err_cnt - e0), 32'd0);
        check_eq("f1_cur_ch", 32'(cur_ch), 32'd0);
        check_eq("f1_done_latency", 32'(last_done_cyc - rise16_cyc), 32'(SYNC_STAGES + 2));
        check_eq("idle_dout", 32'(spi_if.ADC_Dout), 32'h0);

        // address 5 takes effect for the next frame
        run_frame(16'h2800, 16, 0, 12'h000, 1'b0, dw, nz);
        check_eq("f2_dout", 32'(dw), 32'h0ABC);
        check_eq("f2_cur_ch", 32'(cur_ch), 32'd5);
        check_eq("f2_ch_at_done", 32'(last_done_ch), 32'd5);

        run_frame(16'h2800, 16, 0, 12'h000, 1'b0, dw, nz);
        check_eq("f3_dout", 32'(dw), 32'h0123);
        check_eq("f3_cur_ch", 32'(cur_ch), 32'd5);

        // abort after 7 rising edges with address 3
        d0 = done_cnt; e0 = err_cnt;
        run_frame(16'h1800, 7, 0, 12'h000, 1'b0, dw, nz);
        check_eq("abort_err_cnt", 32'(err_cnt - e0), 32'd1);
        check_eq("abort_done_cnt", 32'(done_cnt - d0), 32'd0);
        check_eq("abort_cur_ch", 32'(cur_ch), 32'd5);

        run_frame(16'h1000, 16, 0, 12'h000, 1'b0, dw, nz);
        check_eq("f4_dout", 32'(dw), 32'h0123);
        check_eq("f4_cur_ch", 32'(cur_ch), 32'd2);

        // ch2 changes after the SS fall; captured value must be returned
        run_frame(16'h3800, 16, 2, 12'h000, 1'b1, dw, nz);
        check_eq("f5_late_change", 32'(dw), 32'h0FFF);
        check_eq("f5_cur_ch", 32'(cur_ch), 32'd7);

        // 20 SCLK cycles in one SS window
        d0 = done_cnt; e0 = err_cnt;
        run_frame(16'h2800, 20, 0, 12'h000, 1'b0, dw, nz);
        check_eq("f6_dout", 32'(dw), 32'h07A5);
        check_eq("f6_done_cnt", 32'(done_cnt - d0), 32'd1);
        check_eq("f6_err_cnt", 32'(err_cnt - e0), 32'd0);
        check_eq("f6_extra_dout", 32'(nz), 32'd0);
        check_eq("f6_cur_ch", 32'(cur_ch), 32'd5);

        // reset in the middle of a frame
        d0 = done_cnt; e0 = err_cnt;
        spi_if.ADC_ss = 1'b0;
        tick(HALF);
        for (int k = 1; k <= 5; k++) begin
            spi_if.ADC_sclk = 1'b0;
            spi_if.ADC_Din  = (k == 3 || k == 4 || k == 5) ? 1'b1 : 1'b0;
            tick(HALF);
            spi_if.ADC_sclk = 1'b1;
            tick(HALF);
        end
        rst = 1'b1;
        tick(2);
        check_eq("midrst_dout", 32'(spi_if.ADC_Dout), 32'h0);
        check_eq("midrst_cur_ch", 32'(cur_ch), 32'd0);
        spi_if.ADC_ss  = 1'b1;
        spi_if.ADC_Din = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(2 * HALF);
        check_eq("midrst_done_cnt", 32'(done_cnt - d0), 32'd0);
        check_eq("midrst_err_cnt", 32'(err_cnt - e0), 32'd0);
        check_eq("midrst_cur_ch_after", 32'(cur_ch), 32'd0);

        run_frame(16'h0000, 16, 0, 12'h000, 1'b0, dw, nz);
        check_eq("f7_dout", 32'(dw), 32'h0ABC);
        check_eq("f7_cur_ch", 32'(cur_ch), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
